// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and the
// read-return owner encoding.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W       = 3;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

endpackage

// File: rtl/wait_counter.sv
// Saturating wait counter with synchronous clear; flags when the aux port
// has waited long enough to force a grant.
module wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: CPU has priority, the aux port is forced in
// after MAX_WAIT cycles of waiting; read data is routed back one cycle later.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  cpu_gnt_cnt,
    output logic [CNT_W-1:0]  aux_gnt_cnt
);

    logic              wait_at_max;
    logic              cpu_gnt;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] aux_rdata_q;
    logic [CNT_W-1:0]  cpu_cnt_q, aux_cnt_q;

    wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (aux_req && !aux_gnt),
        .clr_i    (aux_gnt || !aux_req),
        .at_max_o (wait_at_max)
    );

    // Aux wins only when the CPU is idle or aux has been starved long enough.
    always_comb begin
        aux_gnt   = 1'b0;
        cpu_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (!rst) begin
            aux_gnt   = aux_req && (wait_at_max || !cpu_req);
            cpu_gnt   = cpu_req && !aux_gnt;
            cpu_stall = cpu_req && aux_gnt;
        end
    end

    always_comb begin
        mem_en    = cpu_gnt || aux_gnt;
        mem_we    = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        owner_d   = OWN_NONE;
        if (aux_gnt) begin
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            if (!aux_we) owner_d = OWN_AUX;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) owner_d = OWN_CPU;
        end
    end

    // Gating by rst kills a read whose grant landed just before reset.
    always_comb begin
        cpu_rvalid = !rst && (owner_q == OWN_CPU);
        aux_rvalid = !rst && (owner_q == OWN_AUX);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        aux_rdata  = aux_rvalid ? mem_rdata : aux_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
            cpu_cnt_q   <= '0;
            aux_cnt_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
            cpu_rdata_q <= cpu_rdata;
            aux_rdata_q <= aux_rdata;
            if (cpu_gnt) cpu_cnt_q <= cpu_cnt_q + CNT_W'(1);
            if (aux_gnt) aux_cnt_q <= aux_cnt_q + CNT_W'(1);
        end
    end

    assign cpu_gnt_cnt = cpu_cnt_q;
    assign aux_gnt_cnt = aux_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset corner cases, random
// traffic against a transaction-level model, and counter wrap.
module tb_mem_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, aux_req, aux_we;
    logic [AW-1:0] cpu_addr, aux_addr;
    logic [DW-1:0] cpu_wdata, aux_wdata;
    logic          cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid;
    logic [DW-1:0] cpu_rdata, aux_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata_r;
    logic [15:0]   cpu_gnt_cnt, aux_gnt_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata_r),
        .cpu_gnt_cnt(cpu_gnt_cnt), .aux_gnt_cnt(aux_gnt_cnt)
    );

    // Synchronous-read data memory with a preload side door
    logic [DW-1:0] dm [0:31];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) dm[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) dm[mem_addr] <= mem_wdata;
            else        mem_rdata_r  <= dm[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic ar, input logic aw,
                         input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          ar, aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          e_stall, e_gnt, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic          e_crv, e_arv;
        logic [DW-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(int cr, int cw, int ca, int cd, int ar, int aw, int aa, int ad,
                                int st, int g, int en, int we, int ea, int crv, int arv, int rd);
        vec_t v;
        v.cr = 1'(cr);  v.cw = 1'(cw);  v.ca = AW'(ca);  v.cd = DW'(cd);
        v.ar = 1'(ar);  v.aw = 1'(aw);  v.aa = AW'(aa);  v.ad = DW'(ad);
        v.e_stall = 1'(st); v.e_gnt = 1'(g); v.e_en = 1'(en); v.e_we = 1'(we);
        v.e_addr = AW'(ea); v.e_crv = 1'(crv); v.e_arv = 1'(arv); v.e_rd = DW'(rd);
        return v;
    endfunction

    vec_t vecs[$];

    // Model state for the random phase
    logic [DW-1:0] mm [0:31];
    int            wcnt, pend, ccnt, acnt;
    logic [DW-1:0] pend_data;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    logic          s_cr, s_cw, s_ar, s_aw;
    logic [AW-1:0] s_ca, s_aa;
    logic [DW-1:0] s_cd, s_ad;
    logic          a_pend, c_stalled, ea, ec, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        idle();
        next_cycle();

        // Reset holds grants off even with both ports requesting
        drive(1'b1, 1'b0, 5'd1, '0, 1'b1, 1'b0, 5'd2, '0);
        settle();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_aux_gnt", 32'(aux_gnt), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        idle();
        for (int i = 0; i < 32; i++) begin
            pl_en = 1'b1; pl_addr = AW'(i); pl_data = 32'h100 + 32'(i);
            next_cycle();
        end
        pl_addr = 5'd2;  pl_data = 32'h12; next_cycle();
        pl_addr = 5'd3;  pl_data = 32'h9;  next_cycle();
        pl_addr = 5'd10; pl_data = 32'hA;  next_cycle();
        pl_en = 1'b0;
        rst = 1'b0;
        settle();
        chk("rst_cpu_cnt", 32'(cpu_gnt_cnt), 32'd0);
        chk("rst_aux_cnt", 32'(aux_gnt_cnt), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_aux_rdata", aux_rdata, 32'd0);
        next_cycle();

        //          cr cw ca cd      ar aw aa ad      st g en we ea crv arv rd
        vecs.push_back(mk(1,0,2,0,     0,0,0,0,        0,0,1,0,2,  0,0,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,        0,0,0,0,2,  1,0,'h12));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,        0,0,0,0,2,  0,0,0));
        vecs.push_back(mk(1,0,10,0,    1,0,3,0,        0,0,1,0,10, 0,0,0));
        vecs.push_back(mk(1,0,10,0,    1,0,3,0,        0,0,1,0,10, 1,0,'hA));
        vecs.push_back(mk(1,0,10,0,    1,0,3,0,        0,0,1,0,10, 1,0,'hA));
        vecs.push_back(mk(1,0,10,0,    1,0,3,0,        0,0,1,0,10, 1,0,'hA));
        vecs.push_back(mk(1,0,10,0,    1,0,3,0,        1,1,1,0,3,  1,0,'hA));
        vecs.push_back(mk(1,0,10,0,    0,0,0,0,        0,0,1,0,10, 0,1,9));
        vecs.push_back(mk(1,0,10,0,    0,0,0,0,        0,0,1,0,10, 1,0,'hA));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,        0,0,0,0,10, 1,0,'hA));
        vecs.push_back(mk(0,0,0,0,     1,1,7,'h1FFF,   0,1,1,1,7,  0,0,0));
        vecs.push_back(mk(1,0,7,0,     0,0,0,0,        0,0,1,0,7,  0,0,0));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,        0,0,0,0,7,  1,0,'h1FFF));
        vecs.push_back(mk(1,1,2,5,     0,0,0,0,        0,0,1,1,2,  0,0,0));
        vecs.push_back(mk(1,0,2,0,     0,0,0,0,        0,0,1,0,2,  0,0,0));
        vecs.push_back(mk(0,0,0,0,     1,0,3,0,        0,1,1,0,3,  1,0,5));
        vecs.push_back(mk(1,0,2,0,     0,0,0,0,        0,0,1,0,2,  0,1,9));
        vecs.push_back(mk(0,0,0,0,     1,0,3,0,        0,1,1,0,3,  1,0,5));
        vecs.push_back(mk(0,0,0,0,     0,0,0,0,        0,0,0,0,3,  0,1,9));

        foreach (vecs[i]) begin
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad);
            settle();
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_aux_gnt", i), 32'(aux_gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_crv));
            chk($sformatf("v%0d_aux_rvalid", i), 32'(aux_rvalid), 32'(vecs[i].e_arv));
            if (vecs[i].e_crv) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
            if (vecs[i].e_arv) chk($sformatf("v%0d_aux_rdata", i), aux_rdata, vecs[i].e_rd);
            next_cycle();
        end

        // Read granted, then reset in the very next cycle
        drive(1'b1, 1'b0, 5'd2, '0, 1'b0, 1'b0, '0, '0);
        settle();
        chk("rr_grant_en", 32'(mem_en), 32'd1);
        next_cycle();
        idle();
        rst = 1'b1;
        settle();
        chk("rr_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rr_rst_mem_en", 32'(mem_en), 32'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        chk("rr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rr_cpu_cnt", 32'(cpu_gnt_cnt), 32'd0);
        chk("rr_aux_cnt", 32'(aux_gnt_cnt), 32'd0);
        chk("rr_mem_en", 32'(mem_en), 32'd0);
        next_cycle();

        // Random traffic against a transaction-level model
        for (int i = 0; i < 32; i++) mm[i] = dm[i];
        wcnt = 0; pend = 0; pend_data = '0; ccnt = 0; acnt = 0;
        last_a = '0; last_d = '0; a_pend = 1'b0; c_stalled = 1'b0;
        s_cr = 0; s_cw = 0; s_ca = '0; s_cd = '0; s_ar = 0; s_aw = 0; s_aa = '0; s_ad = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!a_pend) begin
                s_ar = ($urandom_range(0, 2) == 0);
                s_aw = 1'($urandom_range(0, 1));
                s_aa = AW'($urandom_range(0, 31));
                s_ad = $urandom;
            end
            if (!c_stalled) begin
                s_cr = ($urandom_range(0, 4) != 0);
                s_cw = 1'($urandom_range(0, 1));
                s_ca = AW'($urandom_range(0, 31));
                s_cd = $urandom;
            end
            drive(s_cr, s_cw, s_ca, s_cd, s_ar, s_aw, s_aa, s_ad);
            settle();
            ea = s_ar && ((wcnt >= MAXW) || !s_cr);
            ec = s_cr && !ea;
            e_we = ea ? s_aw : (ec ? s_cw : 1'b0);
            e_a  = ea ? s_aa : (ec ? s_ca : last_a);
            e_d  = ea ? s_ad : (ec ? s_cd : last_d);
            chk("rnd_stall", 32'(cpu_stall), 32'(s_cr && ea));
            chk("rnd_aux_gnt", 32'(aux_gnt), 32'(ea));
            chk("rnd_mem_en", 32'(mem_en), 32'(ea || ec));
            chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
            chk("rnd_mem_addr", 32'(mem_addr), 32'(e_a));
            chk("rnd_mem_wdata", mem_wdata, e_d);
            chk("rnd_cpu_rvalid", 32'(cpu_rvalid), 32'(pend == 1));
            chk("rnd_aux_rvalid", 32'(aux_rvalid), 32'(pend == 2));
            if (pend == 1) chk("rnd_cpu_rdata", cpu_rdata, pend_data);
            if (pend == 2) chk("rnd_aux_rdata", aux_rdata, pend_data);
            chk("rnd_cpu_cnt", 32'(cpu_gnt_cnt), 32'(ccnt));
            chk("rnd_aux_cnt", 32'(aux_gnt_cnt), 32'(acnt));
            pend = 0;
            if (ea || ec) begin
                last_a = e_a; last_d = e_d;
                if (e_we) mm[e_a] = e_d;
                else begin
                    pend = ea ? 2 : 1;
                    pend_data = mm[e_a];
                end
            end
            if (ea) acnt = (acnt + 1) % 65536;
            if (ec) ccnt = (ccnt + 1) % 65536;
            if (ea || !s_ar) wcnt = 0;
            else if (wcnt < MAXW) wcnt++;
            a_pend = s_ar && !ea;
            c_stalled = s_cr && ea;
            next_cycle();
        end

        // Grant counter wrap
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 65535; n++) next_cycle();
        idle();
        settle();
        chk("wrap_cpu_cnt_ffff", 32'(cpu_gnt_cnt), 32'hFFFF);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b0, '0, '0);
        next_cycle();
        idle();
        settle();
        chk("wrap_cpu_cnt_0", 32'(cpu_gnt_cnt), 32'h0);
        chk("wrap_aux_cnt", 32'(aux_gnt_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, data-memory word-address width (32 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter MAX_WAIT, default 4, maximum cycles the aux port waits while CPU traffic is continuous.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cpu_req  in  1  MEM-stage access request (MemRead|MemWrite).
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_stall  out  1  freeze the pipeline this cycle; request not served.
REQ-011 cpu_rdata / cpu_rvalid  out  DATA_W / 1  read data and its one-cycle valid pulse.
REQ-012 aux_req, aux_we, aux_addr, aux_wdata  in  1/1/ADDR_W/DATA_W  display/switch-loader port.
REQ-013 aux_gnt  out  1  aux request accepted this cycle.
REQ-014 aux_rdata / aux_rvalid  out  DATA_W / 1  aux read data and its valid pulse.
REQ-015 mem_en, mem_we, mem_addr, mem_wdata  out  1/1/ADDR_W/DATA_W  data-memory command.
REQ-016 mem_rdata  in  DATA_W  synchronous-read data, valid one cycle after a mem_en read.
REQ-017 cpu_gnt_cnt, aux_gnt_cnt  out  16 each  served-access counters, wrapping.

Function
REQ-018 At most one requester SHALL be granted per cycle; mem_* SHALL be driven combinationally from the granted port in the same cycle.
REQ-019 Default priority: CPU wins whenever cpu_req=1.
REQ-020 A 3-bit wait counter SHALL increment each cycle with aux_req=1 and aux_gnt=0, saturating at MAX_WAIT.
REQ-021 The counter SHALL clear on aux_gnt or when aux_req=0.
REQ-022 When wait counter == MAX_WAIT and aux_req=1, aux SHALL be granted and, if cpu_req=1, cpu_stall=1 in that cycle.
REQ-023 cpu_stall SHALL be 1 only in a cycle where cpu_req=1 and aux is granted; otherwise 0.
REQ-024 Aux SHALL hold req/we/addr/wdata stable until aux_gnt; the CPU SHALL hold its request while cpu_stall=1.
REQ-025 Neither port requesting: mem_en=0, mem_we=0; mem_addr and mem_wdata SHALL hold their last values.
REQ-026 For a granted read, an owner register SHALL route mem_rdata in the following cycle to cpu_rdata with cpu_rvalid=1, or to aux_rdata with aux_rvalid=1.
REQ-027 Read latency SHALL be exactly 1 cycle from grant; writes produce no rvalid.
REQ-028 Back-to-back grants to alternating owners SHALL each return data correctly with no bubble.
REQ-029 After a forced aux grant, the counter is 0, so a pending cpu_req SHALL win the next cycle.
REQ-030 Each grant SHALL increment the owner's 16-bit counter; 0xFFFF wraps to 0x0000.
REQ-031 aux_gnt=1 with aux_req=0 SHALL never occur.

Reset
REQ-032 With rst=1 at a clock edge, the following SHALL clear to 0: wait counter, owner/rvalid pipeline, both grant counters, all rvalid outputs, cpu_rdata, aux_rdata, mem_addr and mem_wdata.
REQ-033 While rst=1, mem_en, aux_gnt and cpu_stall SHALL be 0.
REQ-034 A read granted in the cycle before reset asserts SHALL NOT produce an rvalid.

Structure
REQ-035 Owner encoding (NONE/CPU/AUX) and the default widths SHALL live in the shared CPU package.
REQ-036 One sub-module, wait_counter (saturating counter with clear), is natural; everything else stays flat.

Verification
REQ-037 CPU read addr 2 only, DM[2]=0x0000_0012 -> next cycle cpu_rvalid=1, cpu_rdata=0x12, cpu_stall never 1.
REQ-038 cpu_req held high for 10 cycles, aux read addr 3 from cycle 0 -> aux_gnt in cycle 4, cpu_stall=1 only in cycle 4, CPU granted in cycle 5.
REQ-039 Aux write addr 7 = 0x1FFF while idle -> aux_gnt same cycle, mem_we=1; a later CPU read of addr 7 returns 0x1FFF.
REQ-040 Alternating CPU read addr 2 / aux read addr 3 (DM=5/9) -> rvalid pulses on consecutive cycles with data 5 then 9.
REQ-041 rst asserted in the cycle after a CPU read grant -> no cpu_rvalid, both counters 0, mem_en=0.
REQ-042 Preload cpu_gnt_cnt to 0xFFFF, then one CPU grant -> cpu_gnt_cnt=0x0000.
